// File: rtl/piso_pkg.sv
// piso_pkg
// Shared definitions for the piso_stream_tx transmitter:
//   state_e   - FSM state encoding (ST_IDLE / ST_SHIFT)
//   LSB_FIRST - bit-order selector value: least-significant bit leaves first
//   MSB_FIRST - bit-order selector value: most-significant bit leaves first
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int unsigned LSB_FIRST = 32'd0;
  localparam int unsigned MSB_FIRST = 32'd1;

endpackage

// File: rtl/piso_bit_cnt.sv
// piso_bit_cnt
// Loadable down-counter that tracks how many bits of the current word are
// still waiting to be shifted out.
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous, active-high reset (count -> 0)
//   load     - load count with load_val
//   load_val - value loaded when load is high
//   dec      - decrement by one (saturates at zero)
//   clr      - force count to zero
//   count    - current count (registered)
//   one_left - count == 1, i.e. the next decrement consumes the final bit
// Priority: reset > clr > load > dec.
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int unsigned CNT_W = 32'd4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             one_left
);

  logic [CNT_W-1:0] count_r;

  // Count register: clear/load/decrement, never wrapping below zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != '0)) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count    = count_r;
  assign one_left = (count_r == CNT_W'(1));

endmodule

// File: rtl/piso_stream_tx.sv
// piso_stream_tx
// Parallel-in/serial-out transmitter. A word is captured through a
// valid/ready load handshake and then shifted out one bit per shift_en
// request, LSB or MSB first. A one-cycle done pulse marks the final bit;
// abort drops the word in progress without a done.
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous, active-high reset
//   load_valid - source offers a word on ip
//   load_ready - block accepts a word (high only in IDLE)
//   ip         - parallel word, captured on load_valid & load_ready
//   shift_en   - consumer requests one bit this cycle
//   abort      - cancel the word in progress
//   s_out      - serial data bit (registered)
//   s_valid    - s_out carries a new bit this cycle
//   done       - pulse with the final bit's s_valid
//   busy       - a word is being shifted
//   bits_left  - bits not yet shifted out
// Edge priority: reset > abort > load > shift.
module piso_stream_tx
  import piso_pkg::state_e, piso_pkg::ST_IDLE, piso_pkg::ST_SHIFT, piso_pkg::LSB_FIRST;
#(
  parameter  int unsigned WIDTH     = 32'd8,
  parameter  int unsigned MSB_FIRST = 32'd0,
  localparam int unsigned CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] ip,
  input  logic             shift_en,
  input  logic             abort,
  output logic             s_out,
  output logic             s_valid,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] bits_left
);

  localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);
  localparam bit               MSB_ORDER = (MSB_FIRST != LSB_FIRST);

  state_e           state_r;
  state_e           next_state_s;
  logic [WIDTH-1:0] sr_r;
  logic [WIDTH-1:0] sr_next_s;
  logic [WIDTH-1:0] sr_shift_s;
  logic             out_bit_s;
  logic             s_out_r;
  logic             s_out_next_s;
  logic             s_valid_r;
  logic             s_valid_next_s;
  logic             done_r;
  logic             done_next_s;
  logic             cnt_load_s;
  logic             cnt_dec_s;
  logic             cnt_clr_s;
  logic             one_left_s;
  logic [CNT_W-1:0] cnt_s;

  piso_bit_cnt #(
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load_s),
    .load_val (WIDTH_CNT),
    .dec      (cnt_dec_s),
    .clr      (cnt_clr_s),
    .count    (cnt_s),
    .one_left (one_left_s)
  );

  // Output-end bit and zero-filled shift toward the output end.
  always_comb begin
    out_bit_s  = 1'b0;
    sr_shift_s = '0;
    if (MSB_ORDER) begin
      out_bit_s  = sr_r[WIDTH-1];
      sr_shift_s = {sr_r[WIDTH-2:0], 1'b0};
    end else begin
      out_bit_s  = sr_r[0];
      sr_shift_s = {1'b0, sr_r[WIDTH-1:1]};
    end
  end

  // Next-state and datapath control; strobes default low every cycle.
  always_comb begin
    next_state_s   = state_r;
    sr_next_s      = sr_r;
    s_out_next_s   = s_out_r;
    s_valid_next_s = 1'b0;
    done_next_s    = 1'b0;
    cnt_load_s     = 1'b0;
    cnt_dec_s      = 1'b0;
    cnt_clr_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // abort in IDLE does nothing except block a same-cycle load.
        if (load_valid && !abort) begin
          next_state_s = ST_SHIFT;
          sr_next_s    = ip;
          s_out_next_s = 1'b0;
          cnt_load_s   = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          next_state_s = ST_IDLE;
          sr_next_s    = '0;
          s_out_next_s = 1'b0;
          cnt_clr_s    = 1'b1;
        end else if (shift_en) begin
          s_out_next_s   = out_bit_s;
          sr_next_s      = sr_shift_s;
          s_valid_next_s = 1'b1;
          cnt_dec_s      = 1'b1;
          // Final bit: return to IDLE so load_ready is up alongside done.
          if (one_left_s) begin
            done_next_s  = 1'b1;
            next_state_s = ST_IDLE;
          end else begin
            next_state_s = ST_SHIFT;
          end
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        sr_next_s    = '0;
        s_out_next_s = 1'b0;
        cnt_clr_s    = 1'b1;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Shift register and registered serial outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_r      <= '0;
      s_out_r   <= 1'b0;
      s_valid_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      sr_r      <= sr_next_s;
      s_out_r   <= s_out_next_s;
      s_valid_r <= s_valid_next_s;
      done_r    <= done_next_s;
    end
  end

  assign load_ready = (state_r == ST_IDLE);
  assign busy       = (state_r == ST_SHIFT);
  assign s_out      = s_out_r;
  assign s_valid    = s_valid_r;
  assign done       = done_r;
  assign bits_left  = cnt_s;

endmodule

// File: tb/tb_piso_stream_tx.sv
// tb_piso_stream_tx
// Drives identical stimulus into an LSB-first and an MSB-first instance of
// piso_stream_tx. Expected bits are queued per instance when a word is
// loaded and compared as s_valid bits appear.
module tb_piso_stream_tx;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         load_valid;
  logic         shift_en;
  logic         abort;
  logic [W-1:0] ip;

  logic       load_ready_w [2];
  logic       s_out_w      [2];
  logic       s_valid_w    [2];
  logic       done_w       [2];
  logic       busy_w       [2];
  logic [3:0] bits_left_w  [2];

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t exp_q [2][$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt [2] = '{0, 0};
  logic last_bit [2] = '{1'b0, 1'b0};
  logic prev_busy [2] = '{1'b0, 1'b0};

  piso_stream_tx #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready_w[0]),
    .ip(ip), .shift_en(shift_en), .abort(abort), .s_out(s_out_w[0]),
    .s_valid(s_valid_w[0]), .done(done_w[0]), .busy(busy_w[0]), .bits_left(bits_left_w[0])
  );

  piso_stream_tx #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready_w[1]),
    .ip(ip), .shift_en(shift_en), .abort(abort), .s_out(s_out_w[1]),
    .s_valid(s_valid_w[1]), .done(done_w[1]), .busy(busy_w[1]), .bits_left(bits_left_w[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: pop and compare each serial bit; check holds during stalls.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (s_valid_w[k] === 1'b1) begin
        if (exp_q[k].size() == 0) begin
          check_eq(k ? "spurious_bit_msb" : "spurious_bit_lsb", s_valid_w[k], 0);
        end else begin
          exp_t e;
          e = exp_q[k].pop_front();
          check_eq(k ? "s_out_msb" : "s_out_lsb", s_out_w[k], e.b);
          check_eq(k ? "done_msb" : "done_lsb", done_w[k], e.last);
        end
        last_bit[k] = s_out_w[k];
        check_eq(k ? "bits_left_msb" : "bits_left_lsb", bits_left_w[k], exp_q[k].size());
        if (done_w[k] === 1'b1) begin
          done_cnt[k]++;
          check_eq(k ? "ready_at_done_msb" : "ready_at_done_lsb", load_ready_w[k], 1);
        end
      end else if (busy_w[k] === 1'b1) begin
        if (!prev_busy[k]) last_bit[k] = 1'b0;
        check_eq(k ? "hold_s_out_msb" : "hold_s_out_lsb", s_out_w[k], last_bit[k]);
        check_eq(k ? "done_wo_valid_msb" : "done_wo_valid_lsb", done_w[k], 0);
        check_eq(k ? "hold_bits_left_msb" : "hold_bits_left_lsb", bits_left_w[k], exp_q[k].size());
      end
      prev_busy[k] = (busy_w[k] === 1'b1);
    end
  end

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      exp_q[0].push_back(exp_t'{w[i], (i == W - 1)});
      exp_q[1].push_back(exp_t'{w[W-1-i], (i == W - 1)});
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50; i++) begin
      if (load_ready_w[0] === 1'b1) break;
      @(posedge clk); #1;
    end
    check_eq("ready_timeout", load_ready_w[0], 1);
  endtask

  task automatic drain(input logic [15:0] pat);
    int d0, d1;
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    for (int i = 0; i < 80; i++) begin
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0) break;
      shift_en = pat[i % 16];
      @(posedge clk); #1;
    end
    shift_en = 1'b0;
    check_eq("drain_timeout", exp_q[0].size() + exp_q[1].size(), 0);
    check_eq("done_count_lsb", done_cnt[0] - d0, 1);
    check_eq("done_count_msb", done_cnt[1] - d1, 1);
    check_eq("end_bits_left", bits_left_w[0], 0);
    check_eq("end_ready", load_ready_w[0], 1);
  endtask

  task automatic load_word(input logic [W-1:0] w);
    wait_ready();
    ip = w;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    push_word(w);
  endtask

  task automatic flush_and_check_idle(input string tag);
    exp_q[0].delete();
    exp_q[1].delete();
    for (int k = 0; k < 2; k++) begin
      check_eq({tag, "_busy"}, busy_w[k], 0);
      check_eq({tag, "_bits_left"}, bits_left_w[k], 0);
      check_eq({tag, "_s_valid"}, s_valid_w[k], 0);
      check_eq({tag, "_s_out"}, s_out_w[k], 0);
      check_eq({tag, "_done"}, done_w[k], 0);
      check_eq({tag, "_ready"}, load_ready_w[k], 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    reset      = 1'b1;
    load_valid = 1'b0;
    shift_en   = 1'b0;
    abort      = 1'b0;
    ip         = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush_and_check_idle("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // 1 and 2: continuous shifting, both bit orders.
    load_word(8'hB4);
    drain(16'hFFFF);

    // 3: stalled shifting.
    load_word(8'hB4);
    drain(16'h9999);

    // 4: load_valid held with a new ip during SHIFT.
    wait_ready();
    ip = 8'hB4;
    load_valid = 1'b1;
    @(posedge clk); #1;
    push_word(8'hB4);
    ip = 8'hFF;
    d0 = done_cnt[0];
    for (int i = 0; i < 40; i++) begin
      shift_en = 1'b1;
      @(posedge clk); #1;
      if (load_ready_w[0] === 1'b1) break;
    end
    check_eq("t4_ready_after_done", load_ready_w[0], 1);
    @(posedge clk); #1;
    load_valid = 1'b0;
    check_eq("t4_first_done", done_cnt[0] - d0, 1);
    check_eq("t4_reload_busy", busy_w[0], 1);
    check_eq("t4_reload_bits_left", bits_left_w[0], 8);
    push_word(8'hFF);
    drain(16'hFFFF);

    // 5: abort after 3 bits, then a fresh word.
    load_word(8'hB4);
    d0 = done_cnt[0];
    shift_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    shift_en = 1'b0;
    flush_and_check_idle("abort");
    @(posedge clk); #1;
    check_eq("abort_no_done", done_cnt[0] - d0, 0);
    load_word(8'h01);
    drain(16'hFFFF);

    // 6: reset mid-word, then reset together with load_valid.
    load_word(8'hB4);
    d0 = done_cnt[0];
    shift_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    flush_and_check_idle("rst_mid");
    shift_en = 1'b0;
    ip = 8'h5A;
    load_valid = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_load_busy", busy_w[0], 0);
    check_eq("rst_load_bits_left", bits_left_w[0], 0);
    reset = 1'b0;
    load_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_ready", load_ready_w[0], 1);
    check_eq("post_rst_busy", busy_w[1], 0);
    check_eq("rst_no_done", done_cnt[0] - d0, 0);
    load_word(8'h3C);
    drain(16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/piso_stream_tx.md
Name: piso_stream_tx

Overview:
Parametrised parallel-in/serial-out transmitter. It is the generalised successor of the team's fixed 4-bit PISO.
- Adds: configurable width, selectable bit order, a load handshake, a bit counter, a completion pulse and abort.
- Sits between a parallel word source (e.g. operand registers of the serial adder) and any bit-serial consumer. The consumer paces shifting via shift_en.

Parameters:
WIDTH, 8, word width in bits (>=2).
MSB_FIRST, 0, 0 = LSB shifted out first, 1 = MSB shifted out first.
CNT_W, $clog2(WIDTH+1), localparam, width of bits_left counter (not overridable).

Ports:
clk  input  1  rising-edge clock, single clock domain.
reset  input  1  synchronous, active-high reset.
load_valid  input  1  source offers a word on ip.
load_ready  output  1  block can accept a word (high only in IDLE).
ip  input  WIDTH  parallel word, captured when load_valid & load_ready.
shift_en  input  1  consumer requests one bit this cycle.
abort  input  1  cancel the word in progress.
s_out  output  1  serial data bit, registered.
s_valid  output  1  s_out carries a new bit this cycle (one cycle per bit).
done  output  1  one-cycle pulse coincident with the final bit's s_valid.
busy  output  1  state == SHIFT.
bits_left  output  CNT_W  bits not yet shifted out.

Behaviour:
Clock and reset (already decided): one clock, clk; reset is synchronous and active-high on port reset.

Reset values:
- Zero: s_out, s_valid, done, busy, bits_left, shift register.
- State = IDLE, so load_ready = 1.

Priority each edge: reset > abort > load > shift.

Decoded outputs (from the state register, not from inputs):
- load_ready = (state == IDLE).
- busy = (state == SHIFT).

IDLE:
- load_valid = 1 and abort = 0: sr <= ip; bits_left <= WIDTH; s_out <= 0; go to SHIFT.
- shift_en is ignored.
- abort is a no-op, but it blocks a load in the same cycle.

SHIFT:
- shift_en = 1:
  - s_out <= sr[0] (MSB_FIRST=0) or sr[WIDTH-1] (MSB_FIRST=1).
  - sr shifts toward the output end, zero-filled.
  - s_valid <= 1; bits_left <= bits_left - 1.
- shift_en = 1 and bits_left == 1: also done <= 1 and state <= IDLE.
- shift_en = 0: s_valid <= 0; s_out, sr and bits_left hold. Stalls of any length are allowed.
- abort = 1:
  - go to IDLE; clear sr, bits_left, s_out, s_valid, done.
  - done is never asserted for an aborted word.
- load_valid is ignored, because load_ready is low.

Timing:
- Load accepted at edge N → first bit visible after edge N+1 at the earliest.
- A word occupies at least WIDTH+1 cycles.
- load_ready is high during the cycle in which done is high, so a new load is accepted at the next edge. Back-to-back throughput is 1 word per WIDTH+1 cycles.

Other rules:
- s_valid and done are single-cycle strobes. done implies s_valid.
- bits_left never wraps below 0.
- reset mid-word: all state is discarded, no done is produced, and outputs go to their reset values on the next edge.

Decomposition:
- Shared package piso_pkg: state encoding constants ST_IDLE = 1'b0, ST_SHIFT = 1'b1, and the bit-order constants LSB_FIRST = 0, MSB_FIRST = 1.
- One natural sub-module: piso_bit_cnt. It is a loadable down-counter with load, dec and clr inputs, plus a one_left flag, parametrised by CNT_W.
- The shift register and FSM stay in the top module.

Test Plan:
1. Reset, then WIDTH=8, MSB_FIRST=0, load ip=8'hB4, shift_en held high → s_out on the 8 s_valid cycles = 0,0,1,0,1,1,0,1; done high with the 8th bit; then load_ready=1, bits_left=0.
2. MSB_FIRST=1, ip=8'hB4 → s_out = 1,0,1,1,0,1,0,0; bits_left steps 8→0.
3. ip=8'hB4 with shift_en pattern 1,0,0,1,1,0,… → s_valid only on shift_en cycles; outputs hold on stalls; order unchanged; exactly one done.
4. load_valid held high and ip changed to 8'hFF during SHIFT → ignored; the original word completes; 8'hFF is accepted the cycle after done.
5. abort after 3 bits of 8'hB4 → next edge: IDLE, bits_left=0, s_valid=0, no done. A following load of 8'h01 then yields 1,0,0,0,0,0,0,0.
6. reset asserted mid-word, and reset asserted simultaneously with load_valid → all outputs at reset values, load not captured, load_ready=1 after reset deasserts.
